// File: rtl/culsans_pkg.sv
// Shared types for the coherent cache slice.
//  - ad_req_t       : kind of request issued by the dcache (single word / full line)
//  - snoop codes    : ACE ARSNOOP / AWSNOOP encodings
//  - ace_ad_state_t : state of the miss adapter FSM
//  - req_t / resp_t : ACE master request / response channel bundles (64-bit data bus)
package culsans_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;

  localparam logic [1:0] DomainNonShare = 2'b00;
  localparam logic [1:0] DomainInner    = 2'b01;
  localparam logic [1:0] BurstIncr      = 2'b01;

  typedef enum logic {SINGLE_REQ, CACHE_LINE_REQ} ad_req_t;

  typedef logic [3:0] arsnoop_t;
  typedef logic [2:0] awsnoop_t;

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, W, B} ace_ad_state_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    awsnoop_t             snoop;
    logic [1:0]           bar;
    logic [1:0]           domain;
    logic                 awunique;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    arsnoop_t             snoop;
    logic [1:0]           bar;
    logic [1:0]           domain;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [3:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  // Non-snooping transactions stay in the non-shareable domain.
  function automatic logic [1:0] snoop_domain(input logic snoop_nonzero);
    return snoop_nonzero ? DomainInner : DomainNonShare;
  endfunction

endpackage

// File: rtl/ace_miss_adapter.sv
// ace_miss_adapter
//  Turns one dcache miss / writeback request at a time into an ACE master
//  transaction (AR/R for reads, AW/W/B for writes), returns the assembled fill
//  line or the write completion, and issues RACK/WACK.
// Ports
//  clk_i, rst_ni            clock, asynchronous active-low reset
//  req_i .. awsnoop_i       request from the dcache, held stable until gnt_o
//  gnt_o                    pulse on the AR/AW handshake (request accepted)
//  valid_o                  one-cycle pulse when the transaction completes
//  rdata_o, rresp_o, err_o  fill line, last R resp, error seen in transaction
//  axi_req_o, axi_resp_i    ACE master port
//  rack_o, wack_o           ACE read / write acknowledges
module ace_miss_adapter
  import culsans_pkg::*;
#(
  parameter int unsigned        CACHELINE_WIDTH = 128,
  parameter logic [IdWidth-1:0] AXI_ID          = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  input  ad_req_t                      type_i,
  input  logic                         we_i,
  input  logic [63:0]                  addr_i,
  input  logic [1:0]                   size_i,
  input  logic [CACHELINE_WIDTH/8-1:0] be_i,
  input  logic [CACHELINE_WIDTH-1:0]   wdata_i,
  input  arsnoop_t                     arsnoop_i,
  input  awsnoop_t                     awsnoop_i,
  output logic                         gnt_o,
  output logic                         valid_o,
  output logic [CACHELINE_WIDTH-1:0]   rdata_o,
  output logic [3:0]                   rresp_o,
  output logic                         err_o,
  output req_t                         axi_req_o,
  input  resp_t                        axi_resp_i,
  output logic                         rack_o,
  output logic                         wack_o
);

  localparam int unsigned BEATS  = CACHELINE_WIDTH / 64;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned OFFS_W = $clog2(CACHELINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  ace_ad_state_t state_q, state_d;

  // Request latch (captured on acceptance in IDLE; inputs are stable until gnt_o)
  logic                       is_line_q;
  logic [63:0]                addr_q;
  logic [1:0]                 size_q;
  logic [BEATS-1:0][7:0]      be_q;
  logic [BEATS-1:0][63:0]     wdata_q;
  arsnoop_t                   arsnoop_q;
  awsnoop_t                   awsnoop_q;

  // Transaction control
  logic [CNT_W-1:0]           cnt_q;
  logic                       aw_done_q;
  logic                       w_done_q;
  logic                       err_q;
  logic [3:0]                 rresp_q;
  logic                       valid_q;
  logic                       rack_q;
  logic                       wack_q;
  logic [BEATS-1:0][63:0]     rdata_q;

  logic aw_fire, w_fire, r_fire, b_fire;
  logic w_last;
  logic [63:0] line_addr;
  ar_chan_t ar_chan;
  aw_chan_t aw_chan;
  w_chan_t  w_chan;

  logic unused_resp;
  assign unused_resp = ^{axi_resp_i.r.id, axi_resp_i.b.id, axi_resp_i.b.resp[0]};

  assign line_addr = is_line_q ? {addr_q[63:OFFS_W], {OFFS_W{1'b0}}} : addr_q;
  assign w_last    = (cnt_q == (is_line_q ? LAST_BEAT : '0));

  always_comb begin
    ar_chan        = '0;
    ar_chan.id     = AXI_ID;
    ar_chan.addr   = line_addr;
    ar_chan.len    = is_line_q ? 8'(BEATS - 1) : 8'd0;
    ar_chan.size   = is_line_q ? 3'd3 : {1'b0, size_q};
    ar_chan.burst  = BurstIncr;
    ar_chan.cache  = is_line_q ? 4'b1111 : 4'b0010;
    ar_chan.snoop  = arsnoop_q;
    ar_chan.domain = snoop_domain(arsnoop_q != '0);

    aw_chan        = '0;
    aw_chan.id     = AXI_ID;
    aw_chan.addr   = line_addr;
    aw_chan.len    = is_line_q ? 8'(BEATS - 1) : 8'd0;
    aw_chan.size   = is_line_q ? 3'd3 : {1'b0, size_q};
    aw_chan.burst  = BurstIncr;
    aw_chan.cache  = is_line_q ? 4'b1111 : 4'b0010;
    aw_chan.snoop  = awsnoop_q;
    aw_chan.domain = snoop_domain(awsnoop_q != '0);

    w_chan         = '0;
    w_chan.data    = wdata_q[cnt_q];
    w_chan.strb    = be_q[cnt_q];
    w_chan.last    = w_last;
  end

  always_comb begin
    state_d   = state_q;
    gnt_o     = 1'b0;
    axi_req_o = '0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    r_fire    = 1'b0;
    b_fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) state_d = we_i ? AW_W : AR;
      end
      AR: begin
        axi_req_o.ar       = ar_chan;
        axi_req_o.ar_valid = 1'b1;
        if (axi_resp_i.ar_ready) begin
          gnt_o   = 1'b1;
          state_d = R;
        end
      end
      R: begin
        axi_req_o.r_ready = 1'b1;
        r_fire            = axi_resp_i.r_valid;
        if (axi_resp_i.r_valid && axi_resp_i.r.last) state_d = IDLE;
      end
      AW_W: begin
        // AW and W run independently; W beats may all complete before AW.
        axi_req_o.aw       = aw_chan;
        axi_req_o.aw_valid = !aw_done_q;
        axi_req_o.w        = w_chan;
        axi_req_o.w_valid  = !w_done_q;
        aw_fire            = !aw_done_q && axi_resp_i.aw_ready;
        w_fire             = !w_done_q && axi_resp_i.w_ready;
        gnt_o              = aw_fire;
        // cnt_q != 0 means a beat went out earlier (w_done_q covers the wrap).
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire || cnt_q != '0))
          state_d = (w_done_q || (w_fire && w_last)) ? B : W;
      end
      W: begin
        axi_req_o.w       = w_chan;
        axi_req_o.w_valid = 1'b1;
        w_fire            = axi_resp_i.w_ready;
        if (axi_resp_i.w_ready && w_last) state_d = B;
      end
      B: begin
        axi_req_o.b_ready = 1'b1;
        b_fire            = axi_resp_i.b_valid;
        if (axi_resp_i.b_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && req_i) begin
      is_line_q <= (type_i == CACHE_LINE_REQ);
      addr_q    <= addr_i;
      size_q    <= size_i;
      be_q      <= be_i;
      wdata_q   <= wdata_i;
      arsnoop_q <= arsnoop_i;
      awsnoop_q <= awsnoop_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      rresp_q   <= '0;
      valid_q   <= 1'b0;
      rack_q    <= 1'b0;
      wack_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      rack_q  <= 1'b0;
      wack_q  <= 1'b0;
      if (state_q == IDLE && req_i) begin
        cnt_q     <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        err_q     <= 1'b0;
      end
      // Extra beats wrap the slot counter; r.last alone terminates the burst.
      if (r_fire) begin
        rdata_q[cnt_q] <= axi_resp_i.r.data;
        cnt_q          <= cnt_q + 1'b1;
        err_q          <= err_q | axi_resp_i.r.resp[1];
        if (axi_resp_i.r.last) begin
          rresp_q <= axi_resp_i.r.resp;
          valid_q <= 1'b1;
          rack_q  <= 1'b1;
        end
      end
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire) begin
        cnt_q <= cnt_q + 1'b1;
        if (w_last) w_done_q <= 1'b1;
      end
      if (b_fire) begin
        err_q   <= err_q | axi_resp_i.b.resp[1];
        valid_q <= 1'b1;
        wack_q  <= 1'b1;
      end
    end
  end

  assign valid_o = valid_q;
  assign rack_o  = rack_q;
  assign wack_o  = wack_q;
  assign err_o   = err_q;
  assign rresp_o = rresp_q;
  assign rdata_o = rdata_q;

endmodule
